reaction_ctrl: RTL and testbench
================================

# reaction_ctrl

Sequencing controller for the reaction-timer game built around the LFSR / BCD display path. It runs the LED fill sequence on LEDR, draws a pseudo-random wait from the LFSR, then measures the player's reaction time in milliseconds. The resulting binary count drives the bin2bcd_16 / hex_to_7seg display chain. It sits between the tick generators, the debounced KEY strobes and the LFSR, and gates LFSR stepping.

## Interface

Parameters:
- LFSR_BITS, 16, width of prbs input
- DELAY_BITS, 13, number of prbs LSBs used for the random wait
- DELAY_MIN, 250, fixed wait offset in ms
- RT_BITS, 16, reaction-time counter width

Ports:
- clk  in  1  system clock (CLOCK_50 at top level)
- rst  in  1  asynchronous, active-high reset
- tick_ms  in  1  one-cycle strobe every 1 ms
- tick_hs  in  1  one-cycle strobe every 0.5 s
- start  in  1  one-cycle debounced start strobe
- stop  in  1  one-cycle debounced stop strobe
- prbs  in  LFSR_BITS  current LFSR state
- lfsr_en  out  1  LFSR step enable
- ledr  out  10  LED pattern
- rt  out  RT_BITS  reaction time, binary ms
- rt_valid  out  1  rt holds a completed measurement
- early  out  1  false start detected
- busy  out  1  game in progress (FILL, DELAY or TIMING)

## Operation

States: IDLE, FILL, DELAY, TIMING, DONE, EARLY.

- IDLE:
  - ledr=0. On start, go to FILL with ledr=0.
- FILL:
  - On each tick_hs, ledr <= {ledr[8:0],1'b1}.
  - On a tick_hs with ledr==10'h3FF, go to DELAY and load cnt <= prbs[DELAY_BITS-1:0] + DELAY_MIN. The range is 250..8441 ms, so cnt is never 0.
- DELAY:
  - ledr stays 10'h3FF. Each tick_ms decrements cnt.
  - On a tick_ms with cnt==1, go to TIMING with ledr=0 and rt=0.
- TIMING:
  - Each tick_ms increments rt, saturating at all-ones.
  - On stop, go to DONE and set rt_valid=1.
- DONE:
  - rt and rt_valid are held. On start, go to FILL and clear rt_valid.
- EARLY:
  - Entered on stop in FILL or DELAY.
  - early=1, ledr=10'h3FF, rt and rt_valid=0.
  - On start, go to FILL and clear early.
- busy = state in {FILL, DELAY, TIMING}.
- lfsr_en = 1 in IDLE, FILL, DONE and EARLY; 0 in DELAY and TIMING. The LFSR free-runs at clock rate while waiting on human input, so the sampled value depends on player timing.
- start in FILL, DELAY or TIMING is ignored.
- stop in IDLE, DONE or EARLY is ignored.
- Simultaneous start and stop: stop wins.
- stop and tick_ms in the same cycle in TIMING: stop wins, rt is not incremented.
- stop and tick_hs in the same cycle in FILL: go to EARLY.
- stop and tick_ms with cnt==1 in the same cycle in DELAY: go to EARLY.

## Timing

- All outputs are registered. Each state or output change appears one clk after the qualifying strobe.
- Reset values (async, any time, including mid-game):
  - state=IDLE, ledr=0, rt=0, rt_valid=0, early=0, busy=0, lfsr_en=1, cnt=0.
- prbs is sampled in the same cycle as the final FILL tick_hs.
- Wait duration in DELAY: exactly cnt tick_ms strobes after entry.
- Reaction time: rt equals the number of tick_ms strobes seen in TIMING before the stop cycle. Resolution is 1 ms, with a 0..1 ms quantisation.
- rt saturates at 2^RT_BITS-1 and never wraps.

## Structure

- Shared package reaction_pkg holds:
  - the state enum (3-bit encoding)
  - DELAY_MIN and DELAY_BITS
  - LED_ALL = 10'h3FF
- One natural sub-module: ms_downcounter. It is a loadable DELAY_BITS+1-bit down counter with tick enable and a zero-next flag.
- The FSM, LED shifter and rt counter stay in reaction_ctrl.

## Test plan

- Reset during TIMING with rt=37 → next cycle state=IDLE, rt=0, ledr=0, lfsr_en=1.
- Normal game with prbs=16'h0000 at sample, stop after 180 tick_ms in TIMING:
  - ledr fills 1,3,7…3FF over 10 tick_hs
  - DELAY lasts 250 tick_ms
  - DONE with rt=180, rt_valid=1
- prbs=16'hFFFF at sample → DELAY lasts 8441 tick_ms (upper 3 bits ignored).
- stop in DELAY after 100 tick_ms → EARLY: early=1, ledr=3FF, rt=0. A following start → FILL with early=0.
- Saturation with RT_BITS=4 → rt holds 15 after 20 tick_ms and stop captures 15.
- Simultaneous events:
  - start+stop in DONE → ignored, rt held
  - stop+tick_ms in TIMING at rt=5 → DONE with rt=5

Source files
------------

// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-timer sequencing controller.
package reaction_pkg;

  localparam int         DELAY_BITS = 13;
  localparam int         DELAY_MIN  = 250;
  localparam logic [9:0] LED_ALL    = 10'h3FF;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FILL   = 3'd1,
    DELAY  = 3'd2,
    TIMING = 3'd3,
    DONE   = 3'd4,
    EARLY  = 3'd5
  } state_t;

endpackage

// File: rtl/reaction_ctrl_ms_downcounter.sv
// Loadable millisecond down counter with a flag marking the last count.
module ms_downcounter #(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic [W-1:0] cnt,
  output logic         last
);

  // Load wins over tick; the count never goes below zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (tick && (cnt != '0))
      cnt <= cnt - W'(1);
  end

  // The next tick takes the counter to zero.
  assign last = (cnt == W'(1));

endmodule

// File: rtl/reaction_ctrl.sv
// Reaction-timer game sequencer: LED fill, random wait, reaction measurement.
module reaction_ctrl #(
  parameter int LFSR_BITS  = 16,
  parameter int DELAY_BITS = reaction_pkg::DELAY_BITS,
  parameter int DELAY_MIN  = reaction_pkg::DELAY_MIN,
  parameter int RT_BITS    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick_ms,
  input  logic                 tick_hs,
  input  logic                 start,
  input  logic                 stop,
  input  logic [LFSR_BITS-1:0] prbs,
  output logic                 lfsr_en,
  output logic [9:0]           ledr,
  output logic [RT_BITS-1:0]   rt,
  output logic                 rt_valid,
  output logic                 early,
  output logic                 busy
);

  import reaction_pkg::*;

  // One extra bit so prbs LSBs plus the fixed offset cannot overflow.
  localparam int                 CW     = DELAY_BITS + 1;
  localparam logic [RT_BITS-1:0] RT_MAX = '1;

  state_t          state;
  state_t          next_state;
  logic            load;
  logic            cnt_last;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   load_val;

  assign load_val = CW'(prbs[DELAY_BITS-1:0]) + CW'(DELAY_MIN);

  ms_downcounter #(
    .W (CW)
  ) u_delay_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .tick     ((state == DELAY) && tick_ms),
    .cnt      (cnt),
    .last     (cnt_last)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= next_state;
  end

  // Next-state decode; stop always takes priority over start and ticks.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    case (state)
      IDLE, DONE, EARLY: begin
        if (start && !stop)
          next_state = FILL;
      end
      FILL: begin
        if (stop)
          next_state = EARLY;
        else if (tick_hs && (ledr == LED_ALL)) begin
          next_state = DELAY;
          load       = 1'b1;
        end
      end
      DELAY: begin
        if (stop)
          next_state = EARLY;
        else if (tick_ms && cnt_last)
          next_state = TIMING;
      end
      TIMING: begin
        if (stop)
          next_state = DONE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Registered outputs, updated on state entry or on in-state strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ledr     <= '0;
      rt       <= '0;
      rt_valid <= 1'b0;
      early    <= 1'b0;
      busy     <= 1'b0;
      lfsr_en  <= 1'b1;
    end else begin
      busy    <= (next_state == FILL) || (next_state == DELAY) ||
                 (next_state == TIMING);
      lfsr_en <= !((next_state == DELAY) || (next_state == TIMING));
      if (next_state != state) begin
        case (next_state)
          FILL: begin
            ledr     <= '0;
            early    <= 1'b0;
            rt_valid <= 1'b0;
          end
          TIMING: begin
            ledr <= '0;
            rt   <= '0;
          end
          DONE: rt_valid <= 1'b1;
          EARLY: begin
            early    <= 1'b1;
            ledr     <= LED_ALL;
            rt       <= '0;
            rt_valid <= 1'b0;
          end
          default: ;
        endcase
      end else if ((state == FILL) && tick_hs) begin
        ledr <= {ledr[8:0], 1'b1};
      end else if ((state == TIMING) && tick_ms && (rt != RT_MAX)) begin
        rt <= rt + RT_BITS'(1);
      end
    end
  end

endmodule

// File: tb/tb_reaction_ctrl.sv
// Scenario bench for reaction_ctrl, with a narrow-rt instance for saturation.
module tb_reaction_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick_ms = 1'b0;
  logic        tick_hs = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] prbs = 16'h0000;

  logic        lfsr_en, rt_valid, early, busy;
  logic [9:0]  ledr;
  logic [15:0] rt;

  logic        b_lfsr_en, b_rt_valid, b_early, b_busy;
  logic [9:0]  b_ledr;
  logic [3:0]  b_rt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_v;

  always #5 clk = ~clk;

  reaction_ctrl dut (
    .clk (clk), .rst (rst), .tick_ms (tick_ms), .tick_hs (tick_hs),
    .start (start), .stop (stop), .prbs (prbs), .lfsr_en (lfsr_en),
    .ledr (ledr), .rt (rt), .rt_valid (rt_valid), .early (early), .busy (busy)
  );

  reaction_ctrl #(.RT_BITS(4)) dut_b (
    .clk (clk), .rst (rst), .tick_ms (tick_ms), .tick_hs (tick_hs),
    .start (start), .stop (stop), .prbs (prbs), .lfsr_en (b_lfsr_en),
    .ledr (b_ledr), .rt (b_rt), .rt_valid (b_rt_valid), .early (b_early),
    .busy (b_busy)
  );

  // One-cycle strobe on any combination of inputs; returns at a negedge,
  // after the outputs have registered the effect.
  task automatic pulse(input logic s_start, input logic s_stop,
                       input logic s_ms, input logic s_hs);
    @(negedge clk);
    start = s_start; stop = s_stop; tick_ms = s_ms; tick_hs = s_hs;
    @(negedge clk);
    start = 1'b0; stop = 1'b0; tick_ms = 1'b0; tick_hs = 1'b0;
  endtask

  task automatic run_fill();
    for (int i = 0; i < 11; i++) pulse(0, 0, 0, 1);
  endtask

  task automatic run_ms(input int n);
    for (int i = 0; i < n; i++) pulse(0, 0, 1, 0);
  endtask

  // Ticks tick_ms until TIMING clears the LEDs (bounded).
  task automatic count_delay(output int n);
    n = 0;
    while (ledr !== 10'h000 && n < 9000) begin
      pulse(0, 0, 1, 0);
      n++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (ledr !== 10'h000) begin n_fail++; $display("FAIL reset_ledr got %h want 000", ledr); end
    n_checks++; if (rt !== 16'd0) begin n_fail++; $display("FAIL reset_rt got %0d want 0", rt); end
    n_checks++; if (rt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rt_valid got %b want 0", rt_valid); end
    n_checks++; if (early !== 1'b0) begin n_fail++; $display("FAIL reset_early got %b want 0", early); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (lfsr_en !== 1'b1) begin n_fail++; $display("FAIL reset_lfsr_en got %b want 1", lfsr_en); end
  endtask

  task automatic test_normal_game();
    int n;
    prbs = 16'h0000;
    pulse(1, 0, 0, 0);
    n_checks++; if (busy !== 1'b1 || ledr !== 10'h000) begin n_fail++; $display("FAIL fill_entry got busy=%b ledr=%h want busy=1 ledr=000", busy, ledr); end
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(16'((1 << (i + 1)) - 1));
      pulse(0, 0, 0, 1);
      exp_v = exp_q.pop_front();
      n_checks++; if (ledr !== exp_v[9:0]) begin n_fail++; $display("FAIL fill_step%0d got %h want %h", i, ledr, exp_v[9:0]); end
    end
    pulse(0, 0, 0, 1);
    n_checks++; if (lfsr_en !== 1'b0 || ledr !== 10'h3FF || busy !== 1'b1) begin n_fail++; $display("FAIL delay_entry got lfsr_en=%b ledr=%h busy=%b want 0/3ff/1", lfsr_en, ledr, busy); end
    exp_q.push_back(16'd250);
    count_delay(n);
    exp_v = exp_q.pop_front();
    n_checks++; if (n !== int'(exp_v)) begin n_fail++; $display("FAIL delay_len_min got %0d want %0d", n, exp_v); end
    n_checks++; if (rt !== 16'd0 || lfsr_en !== 1'b0) begin n_fail++; $display("FAIL timing_entry got rt=%0d lfsr_en=%b want 0/0", rt, lfsr_en); end
    run_ms(180);
    exp_q.push_back(16'd180);
    pulse(0, 1, 0, 0);
    exp_v = exp_q.pop_front();
    n_checks++; if (rt !== exp_v || rt_valid !== 1'b1) begin n_fail++; $display("FAIL done_rt got %0d/%b want %0d/1", rt, rt_valid, exp_v); end
    n_checks++; if (busy !== 1'b0 || lfsr_en !== 1'b1) begin n_fail++; $display("FAIL done_flags got busy=%b lfsr_en=%b want 0/1", busy, lfsr_en); end
  endtask

  task automatic test_start_stop_done();
    exp_q.push_back(16'd180);
    pulse(1, 1, 0, 0);
    pulse(0, 0, 0, 0);
    exp_v = exp_q.pop_front();
    n_checks++; if (rt !== exp_v || rt_valid !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL start_stop_done got rt=%0d v=%b busy=%b want %0d/1/0", rt, rt_valid, busy, exp_v); end
  endtask

  task automatic test_max_delay();
    int n;
    prbs = 16'hFFFF;
    pulse(1, 0, 0, 0);
    n_checks++; if (rt_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL restart got v=%b busy=%b want 0/1", rt_valid, busy); end
    run_fill();
    exp_q.push_back(16'd8441);
    count_delay(n);
    exp_v = exp_q.pop_front();
    n_checks++; if (n !== int'(exp_v)) begin n_fail++; $display("FAIL delay_len_max got %0d want %0d", n, exp_v); end
    run_ms(5);
    exp_q.push_back(16'd5);
    pulse(0, 1, 1, 0);
    exp_v = exp_q.pop_front();
    n_checks++; if (rt !== exp_v || rt_valid !== 1'b1) begin n_fail++; $display("FAIL stop_with_tick got rt=%0d v=%b want %0d/1", rt, rt_valid, exp_v); end
    prbs = 16'h0000;
  endtask

  task automatic test_early();
    pulse(1, 0, 0, 0);
    run_fill();
    run_ms(100);
    pulse(0, 1, 0, 0);
    n_checks++; if (early !== 1'b1 || ledr !== 10'h3FF) begin n_fail++; $display("FAIL early_flags got early=%b ledr=%h want 1/3ff", early, ledr); end
    n_checks++; if (rt !== 16'd0 || rt_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL early_rt got rt=%0d v=%b busy=%b want 0/0/0", rt, rt_valid, busy); end
    pulse(0, 0, 1, 0);
    n_checks++; if (early !== 1'b1) begin n_fail++; $display("FAIL early_hold got %b want 1", early); end
    pulse(1, 0, 0, 0);
    n_checks++; if (early !== 1'b0 || busy !== 1'b1 || ledr !== 10'h000) begin n_fail++; $display("FAIL early_restart got early=%b busy=%b ledr=%h want 0/1/000", early, busy, ledr); end
  endtask

  task automatic test_saturation();
    int n;
    run_fill();
    count_delay(n);
    run_ms(20);
    n_checks++; if (b_rt !== 4'd15 || rt !== 16'd20) begin n_fail++; $display("FAIL sat_run got b_rt=%0d rt=%0d want 15/20", b_rt, rt); end
    pulse(0, 1, 0, 0);
    n_checks++; if (b_rt !== 4'd15 || b_rt_valid !== 1'b1) begin n_fail++; $display("FAIL sat_capture got %0d/%b want 15/1", b_rt, b_rt_valid); end
  endtask

  task automatic test_reset_mid_game();
    int n;
    pulse(1, 0, 0, 0);
    run_fill();
    count_delay(n);
    run_ms(37);
    n_checks++; if (rt !== 16'd37) begin n_fail++; $display("FAIL pre_reset_rt got %0d want 37", rt); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++; if (rt !== 16'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL async_reset got rt=%0d busy=%b want 0/0", rt, busy); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (ledr !== 10'h000 || lfsr_en !== 1'b1 || rt !== 16'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset got ledr=%h lfsr_en=%b rt=%0d busy=%b want 000/1/0/0", ledr, lfsr_en, rt, busy); end
    pulse(0, 0, 1, 0);
    n_checks++; if (busy !== 1'b0 || rt !== 16'd0) begin n_fail++; $display("FAIL idle_after_reset got busy=%b rt=%0d want 0/0", busy, rt); end
  endtask

  initial begin
    test_reset();
    test_normal_game();
    test_start_stop_done();
    test_max_delay();
    test_early();
    test_saturation();
    test_reset_mid_game();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
